button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter N_BTN, default 5: number of independent button channels.
REQ-002 Parameter DEB_CNT, default 1000000: stable cycles needed to accept a press or a release (20 ms at 50 MHz).
REQ-003 Parameter REP_CNT, default 8388608: hold cycles between auto-repeat pulses.
REQ-004 Parameter CNT_W, default 24: counter width; SHALL satisfy 2^CNT_W > max(DEB_CNT, REP_CNT).
REQ-005 board_clk  input  1  system clock; all state changes on its rising edge.
REQ-006 Reset  input  1  asynchronous, active-high reset.
REQ-007 Btn_In  input  N_BTN  raw asynchronous button levels, active-high; channel order {BtnL, BtnU, BtnD, BtnR, BtnC} for N_BTN=5.
REQ-008 Btn_Level  output  N_BTN  debounced level per channel.
REQ-009 Btn_Pulse  output  N_BTN  one-cycle strobe per accepted press.
REQ-010 Btn_Repeat  output  N_BTN  one-cycle strobe every REP_CNT cycles while a press is held.

Function
REQ-011 Each channel SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Each channel SHALL run an independent FSM with states IDLE, WAIT_PRESS, PULSE, HELD, WAIT_RELEASE, plus a CNT_W-bit counter.
REQ-013 IDLE: sync=1 SHALL move to WAIT_PRESS with cnt=0; otherwise stay.
REQ-014 WAIT_PRESS: sync=0 SHALL return to IDLE; otherwise cnt increments, and cnt==DEB_CNT-1 SHALL move to PULSE.
REQ-015 PULSE: lasts exactly one cycle and SHALL move unconditionally to HELD with cnt=0.
REQ-016 HELD: sync=0 SHALL move to WAIT_RELEASE with cnt=0; otherwise cnt increments, and cnt==REP_CNT-1 SHALL assert Btn_Repeat for one cycle and clear cnt.
REQ-017 WAIT_RELEASE: sync=1 SHALL return to HELD with cnt=0 (bounce); otherwise cnt increments, and cnt==DEB_CNT-1 SHALL move to IDLE.
REQ-018 Outputs SHALL be registered, Moore-decoded from state: Btn_Pulse=1 only in PULSE; Btn_Level=1 in PULSE, HELD and WAIT_RELEASE.
REQ-019 Latency: with input stably high from cycle 0, Btn_Pulse SHALL be high exactly in cycle DEB_CNT+3.
REQ-020 Input glitches shorter than DEB_CNT cycles SHALL produce no Btn_Pulse and no Btn_Level change.
REQ-021 Btn_Pulse and Btn_Repeat SHALL never be high in the same cycle on one channel.
REQ-022 The first Btn_Repeat SHALL occur REP_CNT cycles after PULSE.
REQ-023 The counter SHALL never wrap; it is cleared on every state change.
REQ-024 Channels SHALL be fully independent; simultaneous presses on several channels SHALL produce simultaneous pulses when their timing is identical.

Reset
REQ-025 Reset high SHALL force all FSMs to IDLE, all counters and synchronizer flops to 0, and Btn_Level, Btn_Pulse and Btn_Repeat to 0, regardless of board_clk.
REQ-026 Reset asserted mid-press SHALL abort the press with no pulse; after deassertion, a still-held button SHALL be re-qualified from IDLE, with its pulse DEB_CNT+3 cycles after release of Reset.
REQ-027 The BtnR channel SHALL be conditioned normally; because it also drives Reset, it SHALL only report while Reset is low.

Structure
REQ-028 State encodings and the default DEB_CNT and REP_CNT values SHALL live in the shared package flappy_pkg.
REQ-029 One sub-module, debounce_channel (synchronizer, FSM and counter for one button), SHALL be instantiated N_BTN times via generate.
REQ-030 The top-level instantiates this block on board_clk and replaces direct BtnC, BtnU and BtnD use with Btn_Pulse or Btn_Repeat.

Verification (sim parameters DEB_CNT=4, REP_CNT=10)
REQ-031 Reset asserted, then released with Btn_In=0 -> all outputs 0 for 50 cycles.
REQ-032 Btn_In[0] raised at cycle 0 and held -> Btn_Pulse[0] high only in cycle 7; Btn_Level[0]=1 from cycle 7; Btn_Repeat[0] in cycles 17, 27, 37.
REQ-033 Btn_In[1] pulsed high for 3 cycles, repeated 5 times with 3-cycle gaps -> no Btn_Pulse[1], Btn_Level[1] stays 0.
REQ-034 Held channel 2 with release bounces of 2 cycles -> Btn_Level[2] stays 1 and no second pulse; after a clean release, Btn_Level[2]=0 exactly 4 cycles after WAIT_RELEASE entry.
REQ-035 Reset pulsed in cycle 5 of a press on channel 4 -> no pulse before reset; pulse 7 cycles after Reset deasserts.
REQ-036 Channels 0 and 3 raised in the same cycle -> both Btn_Pulse bits high in the same cycle; channel 3 released early -> channel 0 repeat timing unaffected.

Source files
------------

// File: rtl/flappy_pkg.sv
// flappy_pkg: shared button-conditioner state encoding and timing defaults.
package flappy_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PRESS,
        PULSE,
        HELD,
        WAIT_RELEASE
    } btn_state_e;

    localparam int DEB_CNT_DEF = 1000000;
    localparam int REP_CNT_DEF = 8388608;
    localparam int CNT_W_DEF   = 24;

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: synchronizer, debounce FSM and repeat counter for one button.
module debounce_channel
    import flappy_pkg::*;
#(
    parameter int DEB_CNT = DEB_CNT_DEF,
    parameter int REP_CNT = REP_CNT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic board_clk,
    input  logic Reset,
    input  logic btn_in,
    output logic level,
    output logic pulse,
    output logic rep
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CNT - 1);
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REP_CNT - 1);

    logic [1:0]       sync_q;
    logic             sync;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d, pulse_q, pulse_d, rep_q, rep_d;

    assign sync  = sync_q[1];
    assign level = level_q;
    assign pulse = pulse_q;
    assign rep   = rep_q;

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            sync_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            rep_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_in};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            rep_q   <= rep_d;
        end
    end

    // Outputs are decoded from the next state so the registered copy tracks state_q.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (sync) state_d = WAIT_PRESS;
            end
            WAIT_PRESS: begin
                if (!sync) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = PULSE;
                    cnt_d   = '0;
                end
            end
            PULSE: begin
                state_d = HELD;
                cnt_d   = '0;
            end
            HELD: begin
                if (!sync) begin
                    state_d = WAIT_RELEASE;
                    cnt_d   = '0;
                end else if (cnt_q == REP_LAST) begin
                    cnt_d = '0;
                end
            end
            WAIT_RELEASE: begin
                if (sync) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        pulse_d = state_d == PULSE;
        level_d = state_d inside {PULSE, HELD, WAIT_RELEASE};
        rep_d   = state_d == HELD && cnt_d == REP_LAST;
    end

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: per-button debounce, press strobe and auto-repeat for the board buttons.
module button_conditioner
    import flappy_pkg::*;
#(
    parameter int N_BTN   = 5,
    parameter int DEB_CNT = DEB_CNT_DEF,
    parameter int REP_CNT = REP_CNT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             board_clk,
    input  logic             Reset,
    input  logic [N_BTN-1:0] Btn_In,
    output logic [N_BTN-1:0] Btn_Level,
    output logic [N_BTN-1:0] Btn_Pulse,
    output logic [N_BTN-1:0] Btn_Repeat
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        debounce_channel #(
            .DEB_CNT(DEB_CNT),
            .REP_CNT(REP_CNT),
            .CNT_W  (CNT_W)
        ) u_ch (
            .board_clk(board_clk),
            .Reset    (Reset),
            .btn_in   (Btn_In[i]),
            .level    (Btn_Level[i]),
            .pulse    (Btn_Pulse[i]),
            .rep      (Btn_Repeat[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed and random checks against a run-length reference model.
module tb_button_conditioner;

    localparam int N   = 5;
    localparam int DEB = 4;
    localparam int REP = 10;

    logic         board_clk = 1'b0;
    logic         Reset = 1'b1;
    logic [N-1:0] Btn_In = '0;
    logic [N-1:0] Btn_Level, Btn_Pulse, Btn_Repeat;

    int tests = 0;
    int fails = 0;

    // Model: two-sample input delay, then counts of consecutive equal samples.
    logic [N-1:0] m1, m2, lvl, pul, rpt;
    int  run [N];
    int  z   [N];
    int  k   [N];
    bit  skip[N];

    button_conditioner #(
        .N_BTN  (N),
        .DEB_CNT(DEB),
        .REP_CNT(REP),
        .CNT_W  (8)
    ) dut (
        .board_clk (board_clk),
        .Reset     (Reset),
        .Btn_In    (Btn_In),
        .Btn_Level (Btn_Level),
        .Btn_Pulse (Btn_Pulse),
        .Btn_Repeat(Btn_Repeat)
    );

    always #5 board_clk = ~board_clk;

    task automatic chk(string tag, logic [N-1:0] obs, logic [N-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m1  = '0;
        m2  = '0;
        lvl = '0;
        pul = '0;
        rpt = '0;
        for (int c = 0; c < N; c++) begin
            run[c]  = 0;
            z[c]    = 0;
            k[c]    = 0;
            skip[c] = 0;
        end
    endtask

    task automatic model_edge();
        logic [N-1:0] x;
        x   = m2;
        m2  = m1;
        m1  = Btn_In;
        pul = '0;
        rpt = '0;
        for (int c = 0; c < N; c++) begin
            if (!lvl[c]) begin
                run[c] = x[c] ? run[c] + 1 : 0;
                if (run[c] == DEB + 1) begin
                    lvl[c]  = 1'b1;
                    pul[c]  = 1'b1;
                    skip[c] = 1;
                end
            end else if (skip[c]) begin
                skip[c] = 0;
                k[c]    = 0;
                z[c]    = 0;
            end else if (!x[c]) begin
                z[c]++;
                if (z[c] == DEB + 1) begin
                    lvl[c] = 1'b0;
                    run[c] = 0;
                end
            end else if (z[c] > 0) begin
                z[c] = 0;
                k[c] = 0;
            end else begin
                k[c]++;
                rpt[c] = (k[c] % REP) == REP - 1;
            end
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, "_level"}, Btn_Level, lvl);
        chk({tag, "_pulse"}, Btn_Pulse, pul);
        chk({tag, "_repeat"}, Btn_Repeat, rpt);
        chk({tag, "_pulse_and_repeat"}, Btn_Pulse & Btn_Repeat, '0);
    endtask

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge board_clk);
            if (Reset) model_reset();
            else model_edge();
            #1;
            check_all("cycle");
        end
    endtask

    task automatic async_reset(int hold);
        Reset = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        step(hold);
        Reset = 1'b0;
    endtask

    initial begin
        model_reset();
        step(3);
        Reset = 1'b0;
        step(50);

        Btn_In[0] = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            step();
            chk("ch0_pulse_time", N'(Btn_Pulse[0]), N'(t == 7));
            chk("ch0_level_time", N'(Btn_Level[0]), N'(t >= 7));
            chk("ch0_repeat_time", N'(Btn_Repeat[0]), N'(t == 17 || t == 27 || t == 37));
        end
        Btn_In[0] = 1'b0;
        step(10);

        repeat (5) begin
            Btn_In[1] = 1'b1;
            step(3);
            Btn_In[1] = 1'b0;
            step(3);
        end
        chk("ch1_glitch_level", N'(Btn_Level[1]), '0);
        step(5);

        Btn_In[2] = 1'b1;
        step(12);
        repeat (3) begin
            Btn_In[2] = 1'b0;
            step(2);
            Btn_In[2] = 1'b1;
            step(2);
            chk("ch2_bounce_level", N'(Btn_Level[2]), N'(1));
        end
        Btn_In[2] = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            step();
            chk("ch2_release_time", N'(Btn_Level[2]), N'(t < 7));
        end

        Btn_In[4] = 1'b1;
        step(5);
        async_reset(2);
        for (int t = 1; t <= 9; t++) begin
            step();
            chk("ch4_post_reset_pulse", N'(Btn_Pulse[4]), N'(t == 7));
        end
        Btn_In[4] = 1'b0;
        step(12);

        Btn_In[0] = 1'b1;
        Btn_In[3] = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            step();
            chk("ch03_pulse_pair", Btn_Pulse & 5'b01001, (t == 7) ? 5'b01001 : 5'b00000);
            chk("ch0_repeat_indep", N'(Btn_Repeat[0]), N'(t == 17 || t == 27 || t == 37));
            if (t == 10) Btn_In[3] = 1'b0;
        end
        Btn_In = '0;
        step(15);

        for (int t = 0; t < 1500; t++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(15) == 0) Btn_In[c] = ~Btn_In[c];
            if ($urandom_range(299) == 0) async_reset(1);
            else step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
